rob_multi_commit: RTL



---
 rtl/rob_pkg.sv | 33 +++
 rtl/rob_commit_sel.sv | 37 +++
 rtl/rob_multi_commit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared encodings and default sizing for the multi-commit reorder buffer.
package rob_pkg;

  localparam int unsigned ROB_DEPTH    = 16;
  localparam int unsigned ROB_COMMIT_W = 2;
  localparam int unsigned ROB_WB_PORTS = 2;
  localparam int unsigned ROB_PRED_W   = 8;

  typedef enum logic [2:0] {
    K_ALU    = 3'd0,
    K_LOAD   = 3'd1,
    K_STORE  = 3'd2,
    K_BRANCH = 3'd3,
    K_JALR   = 3'd4
  } kind_t;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ISSUED = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic kind_t op_to_kind(input logic [6:0] opcode);
    case (opcode)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BRANCH;
      7'b1100111: return K_JALR;
      default:    return K_ALU;
    endcase
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Picks the in-order retire group starting at head; BRANCH, JALR and STORE close a group.
module rob_commit_sel
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH    = ROB_DEPTH,
  parameter int unsigned COMMIT_W = ROB_COMMIT_W,
  localparam int unsigned IDX_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = $clog2(COMMIT_W + 1)
) (
  input  logic [IDX_W-1:0]                head,
  input  logic [DEPTH-1:0]                done,
  input  kind_t                           kinds [DEPTH],
  output logic [COMMIT_W-1:0]             mask,
  output logic [COMMIT_W-1:0][IDX_W-1:0]  ids,
  output logic [CNT_W-1:0]                n_ret
);

  logic stop;

  always_comb begin
    mask  = '0;
    ids   = '0;
    n_ret = '0;
    stop  = 1'b0;
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      ids[k] = head + IDX_W'(k);
      if (!stop && done[ids[k]]) begin
        mask[k] = 1'b1;
        n_ret   = n_ret + 1'b1;
        if (kinds[ids[k]] inside {K_BRANCH, K_JALR, K_STORE}) stop = 1'b1;
      end else begin
        stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// In-order retirement buffer: one issue per cycle, multi-port write-back, up to COMMIT_W retires per cycle.
module rob_multi_commit
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH    = ROB_DEPTH,
  parameter int unsigned COMMIT_W = ROB_COMMIT_W,
  parameter int unsigned WB_PORTS = ROB_WB_PORTS,
  parameter int unsigned PRED_W   = ROB_PRED_W,
  localparam int unsigned IDX_W   = $clog2(DEPTH)
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              rdy_in,
  input  logic                              iss_req,
  input  logic [2:0]                        iss_kind,
  input  logic [4:0]                        iss_rd,
  input  logic [31:0]                       iss_pc,
  input  logic [31:0]                       iss_imm,
  input  logic                              iss_is_c,
  input  logic                              iss_pred,
  input  logic [PRED_W-1:0]                 iss_gidx,
  input  logic [PRED_W-1:0]                 iss_lidx,
  input  logic [WB_PORTS-1:0]               wb_valid,
  input  logic [WB_PORTS-1:0][IDX_W-1:0]    wb_id,
  input  logic [WB_PORTS-1:0][31:0]         wb_val,
  output logic                              full_out,
  output logic [IDX_W:0]                    count_out,
  output logic [IDX_W-1:0]                  head_out,
  output logic [IDX_W-1:0]                  tail_out,
  output logic [COMMIT_W-1:0]               cm_valid,
  output logic [COMMIT_W-1:0][4:0]          cm_rd,
  output logic [COMMIT_W-1:0][31:0]         cm_val,
  output logic [COMMIT_W-1:0][IDX_W-1:0]    cm_id,
  output logic                              cm_store,
  output logic                              br_ready,
  output logic                              br_res,
  output logic                              br_correct,
  output logic [PRED_W-1:0]                 br_gidx,
  output logic [PRED_W-1:0]                 br_lidx,
  output logic                              jalr_ready,
  output logic [31:0]                       jalr_addr,
  output logic                              flush_out,
  output logic [31:0]                       flush_pc
);

  localparam int unsigned CNT_W = $clog2(COMMIT_W + 1);

  state_t            st_q   [DEPTH];
  kind_t             kind_q [DEPTH];
  logic [4:0]        rd_q   [DEPTH];
  logic [31:0]       pc_q   [DEPTH];
  logic [31:0]       imm_q  [DEPTH];
  logic              isc_q  [DEPTH];
  logic              pred_q [DEPTH];
  logic [PRED_W-1:0] gidx_q [DEPTH];
  logic [PRED_W-1:0] lidx_q [DEPTH];
  logic [31:0]       res_q  [DEPTH];

  logic [DEPTH-1:0]              done_vec;
  logic [COMMIT_W-1:0]           ret_mask;
  logic [COMMIT_W-1:0][IDX_W-1:0] ret_ids;
  logic [CNT_W-1:0]              n_ret;
  logic                          iss_ok;

  kind_t             s_kind [COMMIT_W];
  logic [4:0]        s_rd   [COMMIT_W];
  logic [31:0]       s_res  [COMMIT_W];
  logic              s_pred [COMMIT_W];
  logic [PRED_W-1:0] s_gidx [COMMIT_W];
  logic [PRED_W-1:0] s_lidx [COMMIT_W];
  logic [31:0]       s_link [COMMIT_W];
  logic [31:0]       s_tgt  [COMMIT_W];

  assign full_out = (count_out >= (IDX_W+1)'(DEPTH - 1));
  assign iss_ok   = iss_req && !full_out && !flush_out;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) done_vec[i] = (st_q[i] == ST_DONE);
  end

  rob_commit_sel #(.DEPTH(DEPTH), .COMMIT_W(COMMIT_W)) u_sel (
    .head  (head_out),
    .done  (done_vec),
    .kinds (kind_q),
    .mask  (ret_mask),
    .ids   (ret_ids),
    .n_ret (n_ret)
  );

  always_comb begin
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      s_kind[k] = kind_q[ret_ids[k]];
      s_rd[k]   = rd_q[ret_ids[k]];
      s_res[k]  = res_q[ret_ids[k]];
      s_pred[k] = pred_q[ret_ids[k]];
      s_gidx[k] = gidx_q[ret_ids[k]];
      s_lidx[k] = lidx_q[ret_ids[k]];
      s_link[k] = pc_q[ret_ids[k]] + (isc_q[ret_ids[k]] ? 32'd2 : 32'd4);
      s_tgt[k]  = s_res[k][0] ? pc_q[ret_ids[k]] + imm_q[ret_ids[k]] : s_link[k];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        st_q[i]   <= ST_EMPTY;
        kind_q[i] <= K_ALU;
        rd_q[i]   <= '0;
        pc_q[i]   <= '0;
        imm_q[i]  <= '0;
        isc_q[i]  <= 1'b0;
        pred_q[i] <= 1'b0;
        gidx_q[i] <= '0;
        lidx_q[i] <= '0;
        res_q[i]  <= '0;
      end
      head_out   <= '0;
      tail_out   <= '0;
      count_out  <= '0;
      cm_valid   <= '0;
      cm_rd      <= '0;
      cm_val     <= '0;
      cm_id      <= '0;
      cm_store   <= 1'b0;
      br_ready   <= 1'b0;
      br_res     <= 1'b0;
      br_correct <= 1'b0;
      br_gidx    <= '0;
      br_lidx    <= '0;
      jalr_ready <= 1'b0;
      jalr_addr  <= '0;
      flush_out  <= 1'b0;
      flush_pc   <= '0;
    end else if (rdy_in) begin
      cm_valid   <= '0;
      cm_rd      <= '0;
      cm_val     <= '0;
      cm_id      <= '0;
      cm_store   <= 1'b0;
      br_ready   <= 1'b0;
      br_res     <= 1'b0;
      br_correct <= 1'b0;
      br_gidx    <= '0;
      br_lidx    <= '0;
      jalr_ready <= 1'b0;
      jalr_addr  <= '0;
      flush_out  <= 1'b0;
      flush_pc   <= '0;
      if (flush_out) begin
        // the cycle after a mispredict retires: squash everything, drop this cycle's inputs
        for (int unsigned i = 0; i < DEPTH; i++) st_q[i] <= ST_EMPTY;
        head_out  <= '0;
        tail_out  <= '0;
        count_out <= '0;
      end else begin
        if (iss_ok) begin
          st_q[tail_out]   <= ST_ISSUED;
          kind_q[tail_out] <= kind_t'(iss_kind);
          rd_q[tail_out]   <= iss_rd;
          pc_q[tail_out]   <= iss_pc;
          imm_q[tail_out]  <= iss_imm;
          isc_q[tail_out]  <= iss_is_c;
          pred_q[tail_out] <= iss_pred;
          gidx_q[tail_out] <= iss_gidx;
          lidx_q[tail_out] <= iss_lidx;
          tail_out         <= tail_out + 1'b1;
        end
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
          if (wb_valid[p]) begin
            st_q[wb_id[p]]  <= ST_DONE;
            res_q[wb_id[p]] <= wb_val[p];
          end
        end
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
          if (ret_mask[k]) begin
            st_q[ret_ids[k]] <= ST_EMPTY;
            case (s_kind[k])
              K_ALU, K_LOAD: begin
                cm_valid[k] <= 1'b1;
                cm_rd[k]    <= s_rd[k];
                cm_val[k]   <= s_res[k];
                cm_id[k]    <= ret_ids[k];
              end
              K_JALR: begin
                cm_valid[k] <= 1'b1;
                cm_rd[k]    <= s_rd[k];
                cm_val[k]   <= s_link[k];
                cm_id[k]    <= ret_ids[k];
                jalr_ready  <= 1'b1;
                jalr_addr   <= s_res[k];
              end
              K_STORE: cm_store <= 1'b1;
              K_BRANCH: begin
                br_ready   <= 1'b1;
                br_res     <= s_res[k][0];
                br_correct <= (s_res[k][0] == s_pred[k]);
                br_gidx    <= s_gidx[k];
                br_lidx    <= s_lidx[k];
                if (s_res[k][0] != s_pred[k]) begin
                  flush_out <= 1'b1;
                  flush_pc  <= s_tgt[k];
                end
              end
              default: ;
            endcase
          end
        end
        head_out  <= head_out + IDX_W'(n_ret);
        count_out <= count_out + (IDX_W+1)'(iss_ok) - (IDX_W+1)'(n_ret);
      end
    end
  end

  for (genvar a = 0; a < WB_PORTS; a++) begin : g_wb_a
    for (genvar b = a + 1; b < WB_PORTS; b++) begin : g_wb_b
      a_wb_unique: assert property (@(posedge clk_in) disable iff (rst_in)
        !(rdy_in && wb_valid[a] && wb_valid[b] && wb_id[a] == wb_id[b]));
    end
  end

endmodule
